// File: rtl/dvfs_pkg.sv
// Shared types and constants for the NPU DVFS P-state sequencer.
// Holds the P-state table, FSM encoding and CSR unit conversion.
package dvfs_pkg;

    localparam int unsigned UTIL_W        = 10;
    localparam int unsigned PCT_W         = 7;
    localparam int unsigned MILLI_W       = 11;
    localparam int unsigned MV_W          = 16;
    localparam int unsigned PS_W          = 2;
    localparam int unsigned TBL_ENTRIES   = 4;
    localparam int unsigned MILLI_PER_PCT = 10;

    typedef logic [PS_W-1:0] pstate_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VOLT_UP,
        ST_FREQ_UP,
        ST_FREQ_DN,
        ST_VOLT_DN
    } dvfs_state_t;

    // Index 0 is the slowest operating point.
    localparam logic [MV_W-1:0] PSTATE_FREQ_MHZ [TBL_ENTRIES] = '{16'd200, 16'd400, 16'd600, 16'd800};
    localparam logic [MV_W-1:0] PSTATE_VOLT_MV  [TBL_ENTRIES] = '{16'd600, 16'd700, 16'd800, 16'd900};

    function automatic logic [MILLI_W-1:0] pct_to_milli(input logic [PCT_W-1:0] pct);
        return MILLI_W'(pct) * MILLI_W'(MILLI_PER_PCT);
    endfunction

endpackage

// File: rtl/util_window_avg.sv
// Utilization accumulator over a 2^WIN_LOG2-sample window.
// Average and window_done are combinational on the window's last sample.
module util_window_avg
    import dvfs_pkg::*;
#(
    parameter int unsigned WIN_LOG2 = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              sample_valid,
    input  logic [UTIL_W-1:0] sample,
    output logic [UTIL_W-1:0] avg_c,
    output logic              window_done_c
);

    localparam int unsigned ACC_W = UTIL_W + WIN_LOG2;

    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    sum_c;
    logic [WIN_LOG2-1:0] cnt_q;

    assign sum_c         = acc_q + ACC_W'(sample);
    assign window_done_c = sample_valid && !clear && (cnt_q == '1);
    assign avg_c         = sum_c[ACC_W-1:WIN_LOG2];

    // Accumulate samples; restart at window end or whenever cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (sample_valid) begin
            if (window_done_c) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                acc_q <= sum_c;
                cnt_q <= cnt_q + WIN_LOG2'(1);
            end
        end
    end

endmodule

// File: rtl/dvfs_pstate_sequencer.sv
// Closed-loop DVFS controller: windowed utilization drives one-step P-state
// changes, sequenced volt-before-freq going up and freq-before-volt going down.
module dvfs_pstate_sequencer
    import dvfs_pkg::*;
#(
    parameter int unsigned NUM_PSTATES    = 4,
    parameter int unsigned WIN_LOG2       = 4,
    parameter int unsigned SETTLE_TIMEOUT = 1024,
    parameter int unsigned RESET_PSTATE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              util_valid,
    input  logic [UTIL_W-1:0] util_milli,
    input  logic              util_override_en,
    input  logic [UTIL_W-1:0] util_override_milli,
    input  logic [PCT_W-1:0]  util_high_pct,
    input  logic [PCT_W-1:0]  util_low_pct,
    output logic              vreg_req,
    output logic [MV_W-1:0]   vreg_mv,
    input  logic              vreg_ack,
    output logic              pll_req,
    output logic [MV_W-1:0]   pll_mhz,
    input  logic              pll_lock,
    output logic [PS_W-1:0]   cur_pstate,
    output logic [MV_W-1:0]   cur_freq_mhz,
    output logic [MV_W-1:0]   cur_volt_mv,
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr,
    output logic [15:0]       transition_count
);

    localparam int unsigned TMR_W = $clog2(SETTLE_TIMEOUT + 1);

    dvfs_state_t       state_q, state_d;
    pstate_t           target_q, target_d;
    pstate_t           cur_pstate_q, cur_pstate_d;
    logic              vreg_req_q, vreg_req_d, pll_req_q, pll_req_d;
    logic [MV_W-1:0]   vreg_mv_q, vreg_mv_d, pll_mhz_q, pll_mhz_d;
    logic [MV_W-1:0]   cur_freq_q, cur_freq_d, cur_volt_q, cur_volt_d;
    logic              busy_q, busy_d, timeout_err_q, timeout_err_d;
    logic [15:0]       tcount_q, tcount_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    logic              win_done_c;
    logic [UTIL_W-1:0] avg_c;
    logic [MILLI_W-1:0] hi_c, lo_c, avg_ext_c;
    logic              go_up_c, go_dn_c, timeout_c;
    pstate_t           up_idx_c, dn_idx_c;
    logic [15:0]       tcount_inc_c;

    util_window_avg #(.WIN_LOG2(WIN_LOG2)) u_win (
        .clk           (clk),
        .reset         (reset),
        .clear         (busy_q || !enable),
        .sample_valid  (util_override_en || util_valid),
        .sample        (util_override_en ? util_override_milli : util_milli),
        .avg_c         (avg_c),
        .window_done_c (win_done_c)
    );

    // Threshold decision; a non-increasing hi/lo pair means hold.
    assign hi_c      = pct_to_milli(util_high_pct);
    assign lo_c      = pct_to_milli(util_low_pct);
    assign avg_ext_c = MILLI_W'(avg_c);
    assign up_idx_c  = cur_pstate_q + PS_W'(1);
    assign dn_idx_c  = cur_pstate_q - PS_W'(1);
    assign go_up_c   = win_done_c && (hi_c > lo_c) && (avg_ext_c > hi_c)
                       && (cur_pstate_q < PS_W'(NUM_PSTATES - 1));
    assign go_dn_c   = win_done_c && (hi_c > lo_c) && (avg_ext_c < lo_c)
                       && (cur_pstate_q != '0);
    assign timeout_c = (timer_q == TMR_W'(SETTLE_TIMEOUT - 1));
    assign tcount_inc_c = (tcount_q != 16'hFFFF) ? tcount_q + 16'd1 : tcount_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            target_q      <= PS_W'(RESET_PSTATE);
            cur_pstate_q  <= PS_W'(RESET_PSTATE);
            vreg_req_q    <= 1'b0;
            pll_req_q     <= 1'b0;
            vreg_mv_q     <= PSTATE_VOLT_MV[RESET_PSTATE];
            pll_mhz_q     <= PSTATE_FREQ_MHZ[RESET_PSTATE];
            cur_freq_q    <= PSTATE_FREQ_MHZ[RESET_PSTATE];
            cur_volt_q    <= PSTATE_VOLT_MV[RESET_PSTATE];
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            tcount_q      <= '0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            cur_pstate_q  <= cur_pstate_d;
            vreg_req_q    <= vreg_req_d;
            pll_req_q     <= pll_req_d;
            vreg_mv_q     <= vreg_mv_d;
            pll_mhz_q     <= pll_mhz_d;
            cur_freq_q    <= cur_freq_d;
            cur_volt_q    <= cur_volt_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            tcount_q      <= tcount_d;
            timer_q       <= timer_d;
        end
    end

    // Step sequencing; a timeout drops both requests and keeps committed values.
    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        cur_pstate_d  = cur_pstate_q;
        vreg_req_d    = vreg_req_q;
        pll_req_d     = pll_req_q;
        vreg_mv_d     = vreg_mv_q;
        pll_mhz_d     = pll_mhz_q;
        cur_freq_d    = cur_freq_q;
        cur_volt_d    = cur_volt_q;
        tcount_d      = tcount_q;
        timer_d       = '0;
        timeout_err_d = timeout_err_q && !err_clr;

        case (state_q)
            ST_IDLE: begin
                if (go_up_c) begin
                    target_d   = up_idx_c;
                    vreg_mv_d  = PSTATE_VOLT_MV[up_idx_c];
                    vreg_req_d = 1'b1;
                    state_d    = ST_VOLT_UP;
                end else if (go_dn_c) begin
                    target_d  = dn_idx_c;
                    pll_mhz_d = PSTATE_FREQ_MHZ[dn_idx_c];
                    pll_req_d = 1'b1;
                    state_d   = ST_FREQ_DN;
                end
            end
            ST_VOLT_UP: begin
                if (vreg_ack) begin
                    cur_volt_d = vreg_mv_q;
                    vreg_req_d = 1'b0;
                    pll_mhz_d  = PSTATE_FREQ_MHZ[target_q];
                    pll_req_d  = 1'b1;
                    state_d    = ST_FREQ_UP;
                end else if (timeout_c) begin
                    vreg_req_d    = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_FREQ_UP: begin
                if (pll_lock) begin
                    cur_freq_d   = pll_mhz_q;
                    cur_pstate_d = target_q;
                    pll_req_d    = 1'b0;
                    tcount_d     = tcount_inc_c;
                    state_d      = ST_IDLE;
                end else if (timeout_c) begin
                    pll_req_d     = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_FREQ_DN: begin
                if (pll_lock) begin
                    cur_freq_d   = pll_mhz_q;
                    cur_pstate_d = target_q;
                    pll_req_d    = 1'b0;
                    vreg_mv_d    = PSTATE_VOLT_MV[target_q];
                    vreg_req_d   = 1'b1;
                    state_d      = ST_VOLT_DN;
                end else if (timeout_c) begin
                    pll_req_d     = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_VOLT_DN: begin
                if (vreg_ack) begin
                    cur_volt_d = vreg_mv_q;
                    vreg_req_d = 1'b0;
                    tcount_d   = tcount_inc_c;
                    state_d    = ST_IDLE;
                end else if (timeout_c) begin
                    vreg_req_d    = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                vreg_req_d = 1'b0;
                pll_req_d  = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign vreg_req         = vreg_req_q;
    assign vreg_mv          = vreg_mv_q;
    assign pll_req          = pll_req_q;
    assign pll_mhz          = pll_mhz_q;
    assign cur_pstate       = cur_pstate_q;
    assign cur_freq_mhz     = cur_freq_q;
    assign cur_volt_mv      = cur_volt_q;
    assign busy             = busy_q;
    assign timeout_err      = timeout_err_q;
    assign transition_count = tcount_q;

endmodule

// File: tb/tb_dvfs_pstate_sequencer.sv
// Directed bench for dvfs_pstate_sequencer: step ordering, holds, timeout,
// sparse util_valid windows and asynchronous reset mid-transition.
module tb_dvfs_pstate_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable, util_valid, util_override_en, err_clr;
    logic [9:0]  util_milli, util_override_milli;
    logic [6:0]  util_high_pct, util_low_pct;
    logic        vreg_req, pll_req, vreg_ack, pll_lock, busy, timeout_err;
    logic [15:0] vreg_mv, pll_mhz, cur_freq_mhz, cur_volt_mv, transition_count;
    logic [1:0]  cur_pstate;

    logic vack_en = 1'b1;
    logic lock_en = 1'b1;
    logic vreg_req_prev = 1'b0;
    logic pll_req_prev = 1'b0;
    int   ev_kind[$];
    int   ev_val[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dvfs_pstate_sequencer #(
        .NUM_PSTATES(4), .WIN_LOG2(4), .SETTLE_TIMEOUT(1024), .RESET_PSTATE(0)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .util_valid(util_valid), .util_milli(util_milli),
        .util_override_en(util_override_en), .util_override_milli(util_override_milli),
        .util_high_pct(util_high_pct), .util_low_pct(util_low_pct),
        .vreg_req(vreg_req), .vreg_mv(vreg_mv), .vreg_ack(vreg_ack),
        .pll_req(pll_req), .pll_mhz(pll_mhz), .pll_lock(pll_lock),
        .cur_pstate(cur_pstate), .cur_freq_mhz(cur_freq_mhz), .cur_volt_mv(cur_volt_mv),
        .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr),
        .transition_count(transition_count)
    );

    // Request-rise log (1 = vreg, 2 = pll) plus regulator/PLL responders.
    always @(negedge clk) begin
        if (vreg_req && !vreg_req_prev) begin
            ev_kind.push_back(1);
            ev_val.push_back(int'(vreg_mv));
        end
        if (pll_req && !pll_req_prev) begin
            ev_kind.push_back(2);
            ev_val.push_back(int'(pll_mhz));
        end
        vreg_req_prev = vreg_req;
        pll_req_prev  = pll_req;
        vreg_ack      = vreg_req & vack_en;
        pll_lock      = pll_req & lock_en;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int ps, input int f, input int v, input int cnt);
        check({tag, "_pstate"}, int'(cur_pstate), ps);
        check({tag, "_freq"}, int'(cur_freq_mhz), f);
        check({tag, "_volt"}, int'(cur_volt_mv), v);
        check({tag, "_count"}, int'(transition_count), cnt);
    endtask

    task automatic check_events(input string tag, input int k0, input int v0, input int k1, input int v1);
        check({tag, "_nreq"}, ev_kind.size(), 2);
        if (ev_kind.size() == 2) begin
            check({tag, "_req0_kind"}, ev_kind[0], k0);
            check({tag, "_req0_val"}, ev_val[0], v0);
            check({tag, "_req1_kind"}, ev_kind[1], k1);
            check({tag, "_req1_val"}, ev_val[1], v1);
        end
    endtask

    // Enable an override window, drop enable once busy, and let the step finish.
    task automatic run_step(input string tag, input logic [9:0] ovr);
        int n;
        ev_kind.delete();
        ev_val.delete();
        util_override_milli = ovr;
        util_override_en    = 1'b1;
        enable              = 1'b1;
        n = 0;
        while (!busy && n < 200) begin
            tick();
            n++;
        end
        enable           = 1'b0;
        util_override_en = 1'b0;
        check({tag, "_start_lat"}, n, 16);
        n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        check({tag, "_done"}, int'(busy), 0);
    endtask

    task automatic run_hold(input string tag, input logic [9:0] ovr);
        ev_kind.delete();
        ev_val.delete();
        util_override_milli = ovr;
        util_override_en    = 1'b1;
        enable              = 1'b1;
        repeat (40) tick();
        enable           = 1'b0;
        util_override_en = 1'b0;
        tick();
        check({tag, "_no_req"}, ev_kind.size(), 0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        enable = 1'b0; util_valid = 1'b0; util_milli = '0;
        util_override_en = 1'b0; util_override_milli = '0; err_clr = 1'b0;
        util_high_pct = 7'd80; util_low_pct = 7'd50;
        vreg_ack = 1'b0; pll_lock = 1'b0;
        repeat (3) tick();
        check("rst_vreg_req", int'(vreg_req), 0);
        check("rst_pll_req", int'(pll_req), 0);
        check("rst_vreg_mv", int'(vreg_mv), 600);
        check("rst_pll_mhz", int'(pll_mhz), 200);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(timeout_err), 0);
        check_state("rst", 0, 200, 600, 0);
        reset = 1'b0;
        tick();

        run_step("up01", 10'd900);
        check_events("up01", 1, 700, 2, 400);
        check_state("up01", 1, 400, 700, 1);

        run_step("up12", 10'd900);
        check_state("up12", 2, 600, 800, 2);

        run_step("dn21", 10'd100);
        check_events("dn21", 2, 400, 1, 700);
        check_state("dn21", 1, 400, 700, 3);

        run_hold("hold650", 10'd650);
        util_high_pct = 7'd40; util_low_pct = 7'd60;
        run_hold("miscfg_hi", 10'd1000);
        run_hold("miscfg_lo", 10'd0);
        check_state("miscfg", 1, 400, 700, 3);
        util_high_pct = 7'd80; util_low_pct = 7'd50;

        run_step("up12b", 10'd900);
        run_step("up23", 10'd900);
        check_state("up23", 3, 800, 900, 5);
        run_hold("hold_p3", 10'd1000);
        check("hold_p3_pstate", int'(cur_pstate), 3);
        run_step("dn32", 10'd100);
        check_state("dn32", 2, 600, 800, 6);

        // Up-step with the regulator never acknowledging.
        vack_en = 1'b0;
        util_override_milli = 10'd900;
        util_override_en = 1'b1;
        enable = 1'b1;
        n = 0;
        while (!vreg_req && n < 200) begin
            tick();
            n++;
        end
        enable = 1'b0;
        util_override_en = 1'b0;
        check("to_req_lat", n, 16);
        check("to_vreg_mv", int'(vreg_mv), 900);
        repeat (1023) tick();
        check("to_req_held", int'(vreg_req), 1);
        check("to_err_early", int'(timeout_err), 0);
        tick();
        check("to_req_drop", int'(vreg_req), 0);
        check("to_err_set", int'(timeout_err), 1);
        check("to_busy", int'(busy), 0);
        check("to_pll_req", int'(pll_req), 0);
        check_state("to", 2, 600, 800, 6);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_err_clr", int'(timeout_err), 0);
        vack_en = 1'b1;

        // Sparse util_valid: 16 valid samples, one every third cycle.
        enable = 1'b1;
        util_milli = 10'd950;
        n = 0;
        while (!busy && n < 200) begin
            util_valid = (n % 3 == 0);
            tick();
            n++;
        end
        util_valid = 1'b0;
        enable = 1'b0;
        check("sparse_lat", n, 46);
        n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        check_state("sparse", 3, 800, 900, 7);

        run_step("dn32b", 10'd100);
        check_state("dn32b", 2, 600, 800, 8);

        // Reset asserted while the PLL request is outstanding.
        lock_en = 1'b0;
        util_override_milli = 10'd900;
        util_override_en = 1'b1;
        enable = 1'b1;
        n = 0;
        while (!pll_req && n < 200) begin
            tick();
            n++;
        end
        enable = 1'b0;
        util_override_en = 1'b0;
        check("rfu_pll_req", int'(pll_req), 1);
        reset = 1'b1;
        #1;
        check("rfu_pll_async", int'(pll_req), 0);
        check("rfu_vreg_req", int'(vreg_req), 0);
        check("rfu_busy", int'(busy), 0);
        check("rfu_pll_mhz", int'(pll_mhz), 200);
        check("rfu_vreg_mv", int'(vreg_mv), 600);
        check_state("rfu", 0, 200, 600, 0);
        tick();
        reset = 1'b0;
        lock_en = 1'b1;
        tick();
        run_step("post_rst", 10'd900);
        check_events("post_rst", 1, 700, 2, 400);
        check_state("post_rst", 1, 400, 700, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
